wishbone_rr_arbiter: RTL and testbench

Registered round-robin arbiter that shares one Wishbone slave port between NUM_MASTERS masters. It sits between the host-interface and DMA masters and the shared interconnect slave port. It holds a grant for a whole bus cycle (CYC high), rotates priority fairly, and can optionally abort a stalled slave with a bus error.

---
 rtl/wishbone_rr_arbiter.sv | 93 +++++++++
 tb/tb_wishbone_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter: registered round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters.
// Define WB_RR_ARB_TIMEOUT_EN to build the stall counter that aborts a hung slave with a bus error.
module wishbone_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [NUM_MASTERS-1:0]              m_int_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_int_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_MASTERS);
`ifdef WB_RR_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif
  state_t r_state;
  logic [IW-1:0] r_gnt, r_last, w_nxt;
  logic w_busy;
  logic [NUM_MASTERS-1:0] w_oh;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  // Walk downward in offset so the nearest requester after r_last wins.
  always_comb begin
    w_nxt = r_last;
    for (int i = NUM_MASTERS; i >= 1; i--)
      if (m_cyc_i[(int'(r_last) + i) % NUM_MASTERS]) w_nxt = IW'((int'(r_last) + i) % NUM_MASTERS);
  end

  assign w_busy  = r_state == BUSY;
  assign w_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_gnt;
  assign s_cyc_o = w_busy & m_cyc_i[r_gnt];
  assign s_stb_o = w_busy & m_stb_i[r_gnt];
  assign s_we_o  = w_busy & m_we_i[r_gnt];
  assign s_sel_o = w_busy ? m_sel_i[r_gnt*SW +: SW] : '0;
  assign s_adr_o = w_busy ? m_adr_i[r_gnt*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_dat_o = w_busy ? m_dat_i[r_gnt*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_ack_o = (w_busy && s_ack_i) ? w_oh : '0;
  assign m_dat_o = s_dat_i;
  assign m_int_o = {NUM_MASTERS{s_int_i}};

`ifdef WB_RR_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  assign m_err_o = (r_state == ERR && m_stb_i[r_gnt]) ? w_oh : '0;
  always_ff @(posedge clk) begin
    if (rst || !w_busy || s_ack_i || !m_stb_i[r_gnt]) r_cnt <= '0;
    else if (r_cnt != '1) r_cnt <= r_cnt + 16'd1;
  end
`else
  assign m_err_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
    end else if (r_state == IDLE) begin
      if (|m_cyc_i) begin
        r_gnt   <= w_nxt;
        r_last  <= w_nxt;
        r_state <= BUSY;
      end
    end else if (!m_cyc_i[r_gnt]) r_state <= IDLE;
`ifdef WB_RR_ARB_TIMEOUT_EN
    else if (w_busy && r_cnt == 16'(TIMEOUT_CYCLES - 1) && !s_ack_i) r_state <= ERR;
`endif
  end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter: directed checks of grant order, data muxing, ack/err routing and reset.
module tb_wishbone_rr_arbiter;
  logic clk = 0, rst = 1;
  logic [3:0] m_cyc = 0, m_stb = 0, m_we = 0;
  logic [15:0] m_sel = 0;
  logic [127:0] m_adr = 0, m_dat = 0;
  logic [31:0] m_dat_o, s_dat_i = 0, s_adr_o, s_dat_o;
  logic [3:0] m_ack_o, m_err_o, m_int_o, s_sel_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i = 0, s_int_i = 0;
  int n_chk = 0, n_err = 0;

  wishbone_rr_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_int_o(m_int_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic c, input logic [31:0] a, input logic [31:0] d, input logic we);
    m_cyc[k] = c;
    m_stb[k] = c;
    m_we[k] = we;
    m_adr[k*32 +: 32] = a;
    m_dat[k*32 +: 32] = d;
    m_sel[k*4 +: 4] = 4'(1 << k);
  endtask

  // Entered on the cycle the grant to master k should be visible.
  task automatic serve(input int k, input bit rereq);
    chk("gnt_cyc", s_cyc_o, 1);
    chk("gnt_idx", s_adr_o, k);
    s_ack_i = 1;
    #1 chk("gnt_ack", m_ack_o, 1 << k);
    step;
    s_ack_i = 0;
    req(k, 0, 32'(k), 0, 0);
    #1 chk("rel_cyc", s_cyc_o, 0);
    step;
    if (rereq) req(k, 1, 32'(k), 0, 0);
    #1 chk("idle_cyc", s_cyc_o, 0);
    step;
  endtask

  initial begin
    s_dat_i = 32'hA5A5A5A5;
    s_int_i = 1;
    step;
    step;
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_adr", s_adr_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_dat", m_dat_o, 32'hA5A5A5A5);
    chk("rst_int", m_int_o, 4'hF);
    rst = 0;
    s_int_i = 0;
    step;
    chk("int_low", m_int_o, 0);
    // single master write
    req(2, 1, 32'h10, 32'hDEADBEEF, 1);
    #1 chk("lat_n", s_cyc_o, 0);
    step;
    chk("lat_n1", s_cyc_o, 1);
    chk("wr_stb", s_stb_o, 1);
    chk("wr_we", s_we_o, 1);
    chk("wr_adr", s_adr_o, 32'h10);
    chk("wr_dat", s_dat_o, 32'hDEADBEEF);
    chk("wr_sel", s_sel_o, 4'h4);
    chk("wr_noack0", m_ack_o, 0);
    step;
    chk("wr_noack1", m_ack_o, 0);
    step;
    s_ack_i = 1;
    #1 chk("wr_ack", m_ack_o, 4'b0100);
    step;
    s_ack_i = 0;
    req(2, 0, 32'h10, 32'hDEADBEEF, 1);
    #1 chk("wr_ack_one", m_ack_o, 0);
    step;
    s_ack_i = 1;
    #1 chk("idle_ack", m_ack_o, 0);
    chk("idle_cyc", s_cyc_o, 0);
    s_ack_i = 0;
    // simultaneous requests after reset
    rst = 1;
    step;
    rst = 0;
    for (int k = 0; k < 4; k++) req(k, 1, 32'(k), 0, 0);
    step;
    for (int k = 0; k < 4; k++) serve(k, 0);
    chk("sim_done", s_cyc_o, 0);
    // fairness: 0 re-requests, 3 keeps requesting
    rst = 1;
    step;
    rst = 0;
    req(0, 1, 0, 0, 0);
    req(3, 1, 3, 0, 0);
    step;
    serve(0, 1);
    serve(3, 1);
    serve(0, 1);
    serve(3, 0);
    serve(0, 0);
    // read data with a waiting master that withdraws
    req(1, 1, 32'h1, 0, 0);
    step;
    req(2, 1, 32'h2, 0, 0);
    s_dat_i = 32'h12345678;
    s_ack_i = 1;
    #1 chk("rd_dat", m_dat_o, 32'h12345678);
    chk("rd_ack", m_ack_o, 4'b0010);
    step;
    s_ack_i = 0;
    req(1, 0, 32'h1, 0, 0);
    req(2, 0, 32'h2, 0, 0);
    step;
    step;
    chk("withdraw", s_cyc_o, 0);
    // stalled slave
    req(0, 1, 0, 0, 0);
    step;
    for (int i = 0; i < 8; i++) begin
      chk("stall_cyc", s_cyc_o, 1);
      step;
    end
`ifdef WB_RR_ARB_TIMEOUT_EN
    chk("to_cyc", s_cyc_o, 0);
    chk("to_stb", s_stb_o, 0);
    chk("to_err", m_err_o, 4'b0001);
    step;
    chk("to_err_hold", m_err_o, 4'b0001);
    req(0, 0, 0, 0, 0);
    #1 chk("to_err_drop", m_err_o, 0);
    step;
    req(1, 1, 32'h1, 0, 0);
    step;
    serve(1, 0);
`else
    chk("nto_cyc", s_cyc_o, 1);
    chk("nto_err", m_err_o, 0);
    req(0, 0, 0, 0, 0);
    step;
    step;
`endif
    // reset in the middle of a transfer
    req(1, 1, 32'h1, 0, 0);
    step;
    chk("rm_gnt", s_adr_o, 1);
    rst = 1;
    step;
    chk("rm_cyc", s_cyc_o, 0);
    rst = 0;
    req(0, 1, 0, 0, 0);
    step;
    chk("rm_first_cyc", s_cyc_o, 1);
    chk("rm_first_idx", s_adr_o, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
